// File: rtl/mag_sweep_pkg.sv
// rtl/mag_sweep_pkg.sv - shared state encoding and widths for the mag sweeper
package mag_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int NUM_VEC = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

endpackage

// File: rtl/mag_settle_timer.sv
// rtl/mag_settle_timer.sv - per-vector settle counter with clear and terminal count
module mag_settle_timer
  import mag_sweep_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == TC_VAL);

endmodule

// File: rtl/mag_sweeper.sv
// rtl/mag_sweeper.sv - drives all 8 vectors onto mag and captures its truth table
// Optional golden-table compare (mismatch/err_idx) is built with MAG_SWEEP_CHECK_EN.
module mag_sweeper
  import mag_sweep_pkg::*;
#(
  parameter int               SETTLE = 2,
  parameter logic [NUM_VEC-1:0] EXPECT = 8'b1110_1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               a,
  output logic               b,
  output logic               c,
  input  logic               f,
  output logic [NUM_VEC-1:0] truth_table
`ifdef MAG_SWEEP_CHECK_EN
  ,
  output logic               mismatch,
  output logic [IDX_W-1:0]   err_idx
`endif
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic             settle_tc;
  logic [IDX_W-1:0] abc_d;
  logic             busy_d, done_d, sample_d;
  logic             sample_q;

  mag_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (state != ST_APPLY),
    .en  (state == ST_APPLY),
    .tc  (settle_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_APPLY;
      ST_APPLY:  if (settle_tc) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = (idx == LAST_IDX) ? ST_DONE : ST_APPLY;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    abc_d    = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    sample_d = 1'b0;
    case (state)
      ST_APPLY:  begin abc_d = idx; busy_d = 1'b1; end
      ST_SAMPLE: begin abc_d = idx; busy_d = 1'b1; sample_d = 1'b1; end
      ST_DONE:   done_d = 1'b1;
      default:   ;
    endcase
  end

  // Outputs lag the state by one cycle; f is captured one cycle after SAMPLE so it
  // still sees the registered vector, giving SETTLE+1 cycles of settle time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      {a, b, c}   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sample_q    <= 1'b0;
      truth_table <= '0;
    end else begin
      {a, b, c} <= abc_d;
      busy      <= busy_d;
      done      <= done_d;
      sample_q  <= sample_d;
      if (state == ST_IDLE && start) begin
        idx <= '0;
      end else if (state == ST_SAMPLE && idx != LAST_IDX) begin
        idx <= idx + 1'b1;
      end
      if (state == ST_IDLE && start) begin
        truth_table <= '0;
      end else if (sample_q) begin
        truth_table[{a, b, c}] <= f;
      end
    end
  end

`ifdef MAG_SWEEP_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch <= 1'b0;
      err_idx  <= '0;
    end else if (state == ST_IDLE && start) begin
      mismatch <= 1'b0;
      err_idx  <= '0;
    end else if (sample_q && !mismatch && (f != EXPECT[{a, b, c}])) begin
      mismatch <= 1'b1;
      err_idx  <= {a, b, c};
    end
  end
`else
  logic unused_expect;
  assign unused_expect = ^EXPECT;
`endif

endmodule

// File: tb/tb_mag_sweeper.sv
// tb/tb_mag_sweeper.sv - scoreboard bench for mag_sweeper (SETTLE=2 and SETTLE=1 instances)
module tb_mag_sweeper;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start2 = 1'b0, start1 = 1'b0, f_zero = 1'b0;
  logic busy2, done2, a2, b2, c2, f2;
  logic busy1, done1, a1, b1, c1, f1;
  logic [7:0] tt2, tt1;
`ifdef MAG_SWEEP_CHECK_EN
  logic mis2, mis1;
  logic [2:0] ei2, ei1;
`endif

  // Bench-side mag: 3-input majority.
  assign f2 = f_zero ? 1'b0 : ((a2 & b2) | (a2 & c2) | (b2 & c2));
  assign f1 = (a1 & b1) | (a1 & c1) | (b1 & c1);

  mag_sweeper #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .a(a2), .b(b2), .c(c2), .f(f2), .truth_table(tt2)
`ifdef MAG_SWEEP_CHECK_EN
    , .mismatch(mis2), .err_idx(ei2)
`endif
  );

  mag_sweeper #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .a(a1), .b(b1), .c(c1), .f(f1), .truth_table(tt1)
`ifdef MAG_SWEEP_CHECK_EN
    , .mismatch(mis1), .err_idx(ei1)
`endif
  );

  typedef struct {
    logic [7:0] tt;
    int         done_at;
    logic       mis;
    logic [2:0] ei;
  } exp_t;

  exp_t q2[$];
  exp_t q1[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse pops one expected sweep result.
  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut2_extra_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("dut2_done_edge", cyc, e.done_at);
        chk("dut2_table", int'(tt2), int'(e.tt));
`ifdef MAG_SWEEP_CHECK_EN
        chk("dut2_mismatch", int'(mis2), int'(e.mis));
        if (e.mis) chk("dut2_err_idx", int'(ei2), int'(e.ei));
`endif
      end
    end
    if (done1) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut1_extra_done actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("dut1_done_edge", cyc, e.done_at);
        chk("dut1_table", int'(tt1), int'(e.tt));
`ifdef MAG_SWEEP_CHECK_EN
        chk("dut1_mismatch", int'(mis1), int'(e.mis));
`endif
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while ((q2.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (q2.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d required=0 pending", q2.size() + q1.size());
      q2.delete();
      q1.delete();
    end
  endtask

  // One SETTLE=2 sweep; vectors step every 3 cycles, done at edge k+25.
  task automatic sweep2(input logic [7:0] tt, input logic mis, input logic [2:0] ei,
                        input bit glitch);
    int k;
    exp_t e;
    @(posedge clk); #1;
    start2 = 1'b1;
    k = cyc + 1;
    e.tt = tt; e.done_at = k + 25; e.mis = mis; e.ei = ei;
    q2.push_back(e);
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int ed = k + 1; ed <= k + 25; ed++) begin
      @(posedge clk); #1;
      if (ed <= k + 24) begin
        chk("dut2_vector", int'({a2, b2, c2}), (ed - k - 1) / 3);
        chk("dut2_busy_high", int'(busy2), 1);
      end else begin
        chk("dut2_busy_fall", int'(busy2), 0);
      end
      if (glitch && ed == k + 7) start2 = 1'b1;
      if (glitch && ed == k + 8) start2 = 1'b0;
    end
    wait_drain();
  endtask

  initial begin
    int k;
    exp_t e;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy2), 0);
    chk("rst_done", int'(done2), 0);
    chk("rst_abc", int'({a2, b2, c2}), 0);
    chk("rst_table", int'(tt2), 0);
    chk("rst_busy1", int'(busy1), 0);
`ifdef MAG_SWEEP_CHECK_EN
    chk("rst_mismatch", int'(mis2), 0);
`endif
    rst = 1'b0;

    sweep2(8'hE8, 1'b0, 3'd0, 1'b0);
    sweep2(8'hE8, 1'b0, 3'd0, 1'b1);
    f_zero = 1'b1;
    sweep2(8'h00, 1'b1, 3'd3, 1'b0);
    f_zero = 1'b0;
    sweep2(8'hE8, 1'b0, 3'd0, 1'b0);

    // Reset in the middle of vector 4.
    @(posedge clk); #1;
    start2 = 1'b1;
    k = cyc + 1;
    e.tt = 8'hE8; e.done_at = k + 25; e.mis = 1'b0; e.ei = 3'd0;
    q2.push_back(e);
    @(posedge clk); #1;
    start2 = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    chk("pre_rst_vector", int'({a2, b2, c2}), 4);
    chk("pre_rst_table", int'(tt2), 8'h08);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", int'(busy2), 0);
    chk("async_rst_abc", int'({a2, b2, c2}), 0);
    chk("async_rst_table", int'(tt2), 0);
    chk("async_rst_done", int'(done2), 0);
    q2.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", int'(busy2), 0);
    chk("post_rst_idle_abc", int'({a2, b2, c2}), 0);

    // SETTLE=1 with start held: sweeps accepted at k, k+18, k+36.
    @(posedge clk); #1;
    start1 = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      e.tt = 8'hE8; e.done_at = k + 17 + 18 * i; e.mis = 1'b0; e.ei = 3'd0;
      q1.push_back(e);
    end
    repeat (40) @(posedge clk);
    #1;
    start1 = 1'b0;
    wait_drain();
    repeat (30) @(posedge clk);
    #1;
    chk("dut1_idle_after_hold", int'(busy1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
